// File: rtl/mmio_btn_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mmio_btn_pkg
// Purpose  : Shared definitions for the memory-mapped button input block:
//            register offsets within the 4-word window, the default window
//            base address and the packing rule that places the per-button
//            press counters into the 32-bit COUNT register.
// Revision : 1.0 - initial release
// ============================================================================
package mmio_btn_pkg;

    // Register offsets from the window base address
    localparam logic [1:0] OFF_STATUS = 2'd0;
    localparam logic [1:0] OFF_EVENT  = 2'd1;
    localparam logic [1:0] OFF_COUNT  = 2'd2;
    localparam logic [1:0] OFF_MASK   = 2'd3;

    localparam logic [11:0] c_default_base_addr = 12'hFF0;
    localparam int          c_count_word_w      = 32;

    // COUNT packs counter i at bit i*cnt_w upwards: {.., cnt[1], cnt[0]}.
    function automatic int count_lsb(input int idx, input int cnt_w);
        return idx * cnt_w;
    endfunction

    // Number of bits of counter idx that land inside the 32-bit COUNT word;
    // counters beyond the word are still kept but never read back.
    function automatic int count_visible_bits(input int idx, input int cnt_w);
        int lsb;
        lsb = idx * cnt_w;
        if (lsb >= c_count_word_w)
            return 0;
        else if (lsb + cnt_w > c_count_word_w)
            return c_count_word_w - lsb;
        else
            return cnt_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mmio_button_in_debounce.sv
`default_nettype none
// ============================================================================
// Module   : btn_debounce
// Purpose  : One button input path: 2-flop synchroniser, debounce counter,
//            debounced level and a one-cycle rise (press) pulse.
// Ports    : clk      - system clock
//            reset_n  - asynchronous active-low reset
//            raw      - raw asynchronous button level
//            level    - debounced level
//            rise     - one-cycle pulse, high the first cycle level reads 1
// Revision : 1.0 - initial release
// ============================================================================
module btn_debounce #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic level,
    output logic rise
);

    logic        r_sync1;
    logic        r_sync2;
    logic        r_level;
    logic        r_rise;
    logic [15:0] r_cnt;

    logic        w_differ;
    logic        w_accept;

    // The counter measures how long the synchronised input has disagreed
    // with the accepted level; any agreeing sample restarts the measurement.
    assign w_differ = r_sync2 ^ r_level;
    assign w_accept = w_differ && (r_cnt == (DEBOUNCE_CYCLES - 16'd1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= raw;
            r_sync2 <= r_sync1;
            if (!w_differ || w_accept)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + 16'd1;
            if (w_accept)
                r_level <= ~r_level;
            // Only an accepted 0->1 change is a press.
            r_rise <= w_accept && !r_level;
        end
    end

    assign level = r_level;
    assign rise  = r_rise;

endmodule
`default_nettype wire

// File: rtl/mmio_button_in.sv
`default_nettype none
// ============================================================================
// Module   : mmio_button_in
// Purpose  : Memory-mapped push-button input peripheral on the dmem bus.
//            Debounces NUM_BTN buttons, latches sticky press events (W1C)
//            and keeps a wrapping press counter per button.
//            Window (word offsets from BASE_ADDR):
//              0 STATUS (RO) debounced levels
//              1 EVENT  sticky press flags, write 1 to clear
//              2 COUNT  packed counters, any write clears all
//              3 MASK   interrupt mask (only with MMIO_BTN_IRQ_EN)
// Options  : `define MMIO_BTN_IRQ_EN adds the MASK register and the irq
//            output irq = registered |(EVENT & MASK); otherwise MASK reads 0
//            and irq is tied low.
// Ports    : clk, reset_n (async active-low), btn_raw[NUM_BTN],
//            addr[12], wEn, dataIn[32] - dmem request
//            dataOut[32], hit - registered read data / window select
//            irq - level interrupt
// Revision : 1.0 - initial release
// ============================================================================
module mmio_button_in
    import mmio_btn_pkg::*;
#(
    parameter int          NUM_BTN         = 5,
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
    parameter logic [11:0] BASE_ADDR       = c_default_base_addr,
    parameter int          CNT_W           = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_BTN-1:0] btn_raw,
    input  logic [11:0]        addr,
    input  logic               wEn,
    input  logic [31:0]        dataIn,
    output logic [31:0]        dataOut,
    output logic               hit,
    output logic               irq
);

    localparam int c_used_bits = (NUM_BTN * CNT_W < c_count_word_w) ?
                                 NUM_BTN * CNT_W : c_count_word_w;

    logic [NUM_BTN-1:0] w_level;
    logic [NUM_BTN-1:0] w_rise;
    logic [NUM_BTN-1:0] r_event;
    logic [CNT_W-1:0]   r_cnt [NUM_BTN];
    logic [31:0]        r_dout;
    logic               r_hit;

    logic [11:0]        w_off;
    logic               w_in_win;
    logic               w_wr_event;
    logic               w_wr_count;
    logic [NUM_BTN-1:0] w_w1c;
    logic [NUM_BTN-1:0] w_mask_rd;
    logic [31:0]        w_count_word;
    logic [31:0]        w_rdata;
    logic               w_unused_bits;

    // ------------------------------------------------------------------
    // Per-button input paths
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk     (clk),
            .reset_n (reset_n),
            .raw     (btn_raw[g]),
            .level   (w_level[g]),
            .rise    (w_rise[g])
        );
    end

    // ------------------------------------------------------------------
    // Address decode; subtraction keeps the window test a single compare
    // ------------------------------------------------------------------
    assign w_off      = addr - BASE_ADDR;
    assign w_in_win   = (w_off < 12'd4);
    assign w_wr_event = wEn && w_in_win && (w_off[1:0] == OFF_EVENT);
    assign w_wr_count = wEn && w_in_win && (w_off[1:0] == OFF_COUNT);
    assign w_w1c      = w_wr_event ? dataIn[NUM_BTN-1:0] : '0;

    // Upper write-data bits carry no register state.
    assign w_unused_bits = &{1'b0, dataIn[31:NUM_BTN]};

    // ------------------------------------------------------------------
    // Sticky events (a press in the same cycle as W1C wins) and counters
    // (a press in the same cycle as a clear leaves the count at 1)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_event <= '0;
            for (int i = 0; i < NUM_BTN; i++)
                r_cnt[i] <= '0;
        end else begin
            r_event <= (r_event & ~w_w1c) | w_rise;
            for (int i = 0; i < NUM_BTN; i++) begin
                if (w_wr_count)
                    r_cnt[i] <= w_rise[i] ? CNT_W'(1) : '0;
                else
                    r_cnt[i] <= r_cnt[i] + CNT_W'(w_rise[i]);
            end
        end
    end

    // ------------------------------------------------------------------
    // COUNT word packing
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NUM_BTN; g++) begin : g_count_pack
        localparam int c_lsb = count_lsb(g, CNT_W);
        localparam int c_vis = count_visible_bits(g, CNT_W);
        if (c_vis > 0) begin : g_vis
            assign w_count_word[c_lsb +: c_vis] = r_cnt[g][c_vis-1:0];
        end
    end
    if (c_used_bits < c_count_word_w) begin : g_count_pad
        assign w_count_word[c_count_word_w-1:c_used_bits] = '0;
    end

    // ------------------------------------------------------------------
    // Optional interrupt mask
    // ------------------------------------------------------------------
`ifdef MMIO_BTN_IRQ_EN
    logic [NUM_BTN-1:0] r_mask;
    logic               r_irq;
    logic               w_wr_mask;

    assign w_wr_mask = wEn && w_in_win && (w_off[1:0] == OFF_MASK);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mask <= '0;
            r_irq  <= 1'b0;
        end else begin
            if (w_wr_mask)
                r_mask <= dataIn[NUM_BTN-1:0];
            r_irq <= |(r_event & r_mask);
        end
    end

    assign w_mask_rd = r_mask;
    assign irq       = r_irq;
`else
    assign w_mask_rd = '0;
    assign irq       = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Registered read port, same timing as the synchronous data RAM
    // ------------------------------------------------------------------
    always_comb begin
        w_rdata = '0;
        if (w_in_win) begin
            case (w_off[1:0])
                OFF_STATUS: w_rdata[NUM_BTN-1:0] = w_level;
                OFF_EVENT:  w_rdata[NUM_BTN-1:0] = r_event;
                OFF_COUNT:  w_rdata              = w_count_word;
                OFF_MASK:   w_rdata[NUM_BTN-1:0] = w_mask_rd;
                default:    w_rdata              = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dout <= '0;
            r_hit  <= 1'b0;
        end else begin
            r_dout <= w_rdata;
            r_hit  <= w_in_win;
        end
    end

    assign dataOut = r_dout;
    assign hit     = r_hit;

endmodule
`default_nettype wire
